revcnt_ctrl: RTL and testbench

REVCNT_CTRL -- requirements
Module: revcnt_ctrl

---
 rtl/revcnt_pkg.sv | 18 +
 rtl/ctrl_prescaler.sv | 48 ++++
 rtl/revcnt_ctrl.sv | 154 +++++++++++++++
 tb/tb_revcnt_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/revcnt_pkg.sv
// revcnt_pkg
// Shared definitions for the count sequencer: the FSM state encoding and the
// default prescaler division and counter width.
package revcnt_pkg;

  // Default clk cycles per count step and default counter width.
  localparam int DIV_DEFAULT   = 50_000_000;
  localparam int WIDTH_DEFAULT = 16;

  // Encoding is visible on the state output, so the values are fixed.
  typedef enum logic [1:0] {
    st_idle  = 2'b00,
    st_run   = 2'b01,
    st_pause = 2'b10,
    st_done  = 2'b11
  } state_t;

endpackage

// File: rtl/ctrl_prescaler.sv
// ctrl_prescaler
// Free-running 0..DIV-1 counter used to pace the count steps.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-low reset (count to 0)
//   run  - advance the count, wrapping from DIV-1 to 0
//   hold - keep the present count (overrides run)
//   zero - force the count to 0 (overrides hold and run)
//   tc   - high while the count equals DIV-1
module ctrl_prescaler
  import revcnt_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic hold,
  input  logic zero,
  output logic tc
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] count_reg;
  logic [PW-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (zero) begin
      count_next = '0;
    end else if (run && !hold) begin
      count_next = (count_reg == LAST) ? '0 : count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign tc = (count_reg == LAST);

endmodule

// File: rtl/revcnt_ctrl.sv
// revcnt_ctrl
// Run/pause/clear sequencer for an external up/down counter. Issues one step
// strobe every DIV clk cycles while running, stops at the terminal value when
// wrapping is disabled, and drives a status LED.
// Ports:
//   clk     - system clock, rising edge
//   rst     - synchronous active-low reset
//   start   - one-cycle run request
//   stop    - one-cycle pause request
//   clr     - one-cycle clear-to-idle request
//   dir     - level, 1 = count up, 0 = count down
//   wrap    - level, 1 = wrap at terminal, 0 = halt at terminal
//   cnt     - current value of the sequenced counter
//   cnt_en  - one-cycle step strobe to the counter
//   cnt_dir - dir delayed by one cycle
//   cnt_clr - one-cycle clear strobe to the counter
//   state   - current FSM state
//   led     - status indicator
module revcnt_ctrl
  import revcnt_pkg::*;
#(
  parameter int DIV   = DIV_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clr,
  input  logic             dir,
  input  logic             wrap,
  input  logic [WIDTH-1:0] cnt,
  output logic             cnt_en,
  output logic             cnt_dir,
  output logic             cnt_clr,
  output logic [1:0]       state,
  output logic             led
);

  state_t state_reg;
  state_t state_next;
  logic   cnt_en_reg;
  logic   cnt_en_next;
  logic   cnt_clr_reg;
  logic   cnt_dir_reg;
  logic   led_reg;
  logic   led_next;

  logic ps_run;
  logic ps_hold;
  logic ps_zero;
  logic ps_tc;
  logic terminal;

  ctrl_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .run (ps_run),
    .hold(ps_hold),
    .zero(ps_zero),
    .tc  (ps_tc)
  );

  // Terminal is judged against the direction the counter is actually using.
  assign terminal = cnt_dir_reg ? (cnt == '1) : (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= st_idle;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_en_next = 1'b0;
    ps_zero     = 1'b0;
    ps_hold     = 1'b0;
    ps_run      = (state_reg == st_run) || (state_reg == st_done);

    if (clr) begin
      state_next = st_idle;
      ps_zero    = 1'b1;
    end else begin
      case (state_reg)
        st_idle: begin
          ps_zero = 1'b1;
          if (start) state_next = st_run;
        end
        st_run: begin
          if (stop) begin
            // Freeze the prescaler on the stop cycle so the partial period
            // is resumed exactly on the next start.
            state_next = st_pause;
            ps_hold    = 1'b1;
          end else if (ps_tc) begin
            if (terminal && !wrap) begin
              state_next = st_done;
              ps_zero    = 1'b1;
            end else begin
              cnt_en_next = 1'b1;
            end
          end
        end
        st_pause: begin
          ps_hold = 1'b1;
          if (start) state_next = st_run;
        end
        st_done: begin
          // Only a reversed direction lets the counter move again.
          if (start && !terminal) begin
            state_next = st_run;
            ps_zero    = 1'b1;
          end
        end
        default: state_next = st_idle;
      endcase
    end

    case (state_next)
      st_run:  led_next = 1'b1;
      st_done: begin
        if (state_reg != st_done) led_next = 1'b1;
        else if (ps_tc)           led_next = ~led_reg;
        else                      led_next = led_reg;
      end
      default: led_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_en_reg  <= 1'b0;
      cnt_clr_reg <= 1'b1;
      cnt_dir_reg <= 1'b1;
      led_reg     <= 1'b0;
    end else begin
      cnt_en_reg  <= cnt_en_next;
      cnt_clr_reg <= clr;
      cnt_dir_reg <= dir;
      led_reg     <= led_next;
    end
  end

  assign cnt_en  = cnt_en_reg;
  assign cnt_clr = cnt_clr_reg;
  assign cnt_dir = cnt_dir_reg;
  assign state   = state_reg;
  assign led     = led_reg;

endmodule

// File: tb/tb_revcnt_ctrl.sv
// tb_revcnt_ctrl
// Directed bench for revcnt_ctrl with DIV=4, WIDTH=4. A vector table covers
// reset and steady running; hand-written sequences cover halt at terminal,
// restart from DONE, pause/resume, priority collisions and mid-run reset.
module tb_revcnt_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       clr;
  logic       dir;
  logic       wrap;
  logic [3:0] cnt;
  logic       cnt_en;
  logic       cnt_dir;
  logic       cnt_clr;
  logic [1:0] state;
  logic       led;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  revcnt_ctrl #(
    .DIV  (4),
    .WIDTH(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .clr    (clr),
    .dir    (dir),
    .wrap   (wrap),
    .cnt    (cnt),
    .cnt_en (cnt_en),
    .cnt_dir(cnt_dir),
    .cnt_clr(cnt_clr),
    .state  (state),
    .led    (led)
  );

  typedef struct {
    logic       rst;
    logic       start;
    logic       stop;
    logic       clr;
    logic       dir;
    logic       wrap;
    logic [3:0] cnt;
    logic       e_en;
    logic       e_clr;
    logic       e_dir;
    logic [1:0] e_st;
    logic       e_led;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic e_en, input logic e_clr,
                            input logic e_dir, input logic [1:0] e_st, input logic e_led);
    chk({tag, " cnt_en"},  {3'b0, cnt_en},  {3'b0, e_en});
    chk({tag, " cnt_clr"}, {3'b0, cnt_clr}, {3'b0, e_clr});
    chk({tag, " cnt_dir"}, {3'b0, cnt_dir}, {3'b0, e_dir});
    chk({tag, " state"},   {2'b0, state},   {2'b0, e_st});
    chk({tag, " led"},     {3'b0, led},     {3'b0, e_led});
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; stop = 1'b0; clr = 1'b0;
    dir = 1'b1; wrap = 1'b1; cnt = 4'd0;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; clr = 1'b0;
    dir = 1'b1; wrap = 1'b1; cnt = 4'd0;

    //            rst st sp cl dr wr cnt   en clr dir st     led
    tbl[0]  = '{1'b0, 0, 0, 0, 1, 1, 4'd0, 0, 1, 1, 2'd0, 0};
    tbl[1]  = '{1'b0, 0, 0, 0, 1, 1, 4'd0, 0, 1, 1, 2'd0, 0};
    tbl[2]  = '{1'b1, 0, 0, 0, 1, 1, 4'd0, 0, 0, 1, 2'd0, 0};
    tbl[3]  = '{1'b1, 1, 0, 0, 1, 1, 4'd0, 0, 0, 1, 2'd1, 1};  // start, prescaler 0
    tbl[4]  = '{1'b1, 0, 0, 0, 1, 1, 4'd0, 0, 0, 1, 2'd1, 1};
    tbl[5]  = '{1'b1, 0, 0, 0, 1, 1, 4'd0, 0, 0, 1, 2'd1, 1};
    tbl[6]  = '{1'b1, 0, 0, 0, 1, 1, 4'd0, 0, 0, 1, 2'd1, 1};
    tbl[7]  = '{1'b1, 0, 0, 0, 1, 1, 4'd0, 1, 0, 1, 2'd1, 1};  // 5th cycle after start
    tbl[8]  = '{1'b1, 0, 0, 0, 1, 1, 4'd0, 0, 0, 1, 2'd1, 1};
    tbl[9]  = '{1'b1, 1, 0, 0, 1, 1, 4'd0, 0, 0, 1, 2'd1, 1};  // start in RUN ignored
    tbl[10] = '{1'b1, 0, 0, 0, 1, 1, 4'd0, 0, 0, 1, 2'd1, 1};
    tbl[11] = '{1'b1, 0, 0, 0, 1, 1, 4'd0, 1, 0, 1, 2'd1, 1};  // 9th cycle after start
    tbl[12] = '{1'b1, 0, 0, 0, 0, 1, 4'd5, 0, 0, 0, 2'd1, 1};  // dir delayed one cycle
    tbl[13] = '{1'b1, 0, 0, 0, 1, 1, 4'd5, 0, 0, 1, 2'd1, 1};

    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; stop = tbl[i].stop; clr = tbl[i].clr;
      dir = tbl[i].dir; wrap = tbl[i].wrap; cnt = tbl[i].cnt;
      cyc();
      $display("vec %0d: rst=%0b start=%0b en=%0b clr=%0b dir=%0b state=%0d led=%0b",
               i, rst, start, cnt_en, cnt_clr, cnt_dir, state, led);
      expect_all($sformatf("vec%0d", i), tbl[i].e_en, tbl[i].e_clr, tbl[i].e_dir,
                 tbl[i].e_st, tbl[i].e_led);
    end
    start = 1'b0;
    // Continue the same run: pulses at 13 and 17 cycles after start.
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk($sformatf("run cont %0d cnt_en", k), {3'b0, cnt_en}, (k == 1 || k == 5) ? 4'd1 : 4'd0);
    end
    $display("seq run: continued pulses checked");

    // Halt at terminal: cnt=15 counting up with wrap off.
    do_reset();
    dir = 1'b1; wrap = 1'b0; cnt = 4'd15;
    start = 1'b1; cyc(); start = 1'b0;
    chk("halt start state", {2'b0, state}, 4'd1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("halt pre %0d cnt_en", k), {3'b0, cnt_en}, 4'd0);
    end
    cyc();
    expect_all("halt tick", 1'b0, 1'b0, 1'b1, 2'd3, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk($sformatf("done led %0d", k), {3'b0, led}, (k < 4 || k == 8) ? 4'd1 : 4'd0);
      chk($sformatf("done en %0d", k), {3'b0, cnt_en}, 4'd0);
    end
    $display("seq halt: DONE entered, led toggling checked");

    // Restart from DONE: same direction ignored, reversed direction resumes.
    start = 1'b1; cyc(); start = 1'b0;
    chk("done same-dir start state", {2'b0, state}, 4'd3);
    dir = 1'b0; cyc();
    chk("done reversed cnt_dir", {3'b0, cnt_dir}, 4'd0);
    chk("done reversed state", {2'b0, state}, 4'd3);
    start = 1'b1; cyc(); start = 1'b0;
    chk("done restart state", {2'b0, state}, 4'd1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("restart pre %0d cnt_en", k), {3'b0, cnt_en}, 4'd0);
    end
    cyc();
    expect_all("restart step", 1'b1, 1'b0, 1'b0, 2'd1, 1'b1);
    $display("seq restart: step after reversal checked");

    // Pause at prescaler 2, resume: step comes 2 cycles after restart.
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    expect_all("pause entry", 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk($sformatf("pause hold %0d en", k), {3'b0, cnt_en}, 4'd0);
    end
    chk("pause hold state", {2'b0, state}, 4'd2);
    start = 1'b1; cyc(); start = 1'b0;
    expect_all("resume entry", 1'b0, 1'b0, 1'b1, 2'd1, 1'b1);
    cyc();
    chk("resume +1 cnt_en", {3'b0, cnt_en}, 4'd0);
    cyc();
    chk("resume +2 cnt_en", {3'b0, cnt_en}, 4'd1);
    $display("seq pause: partial period preserved");

    // Stop on the tick cycle, then clr with start together.
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc(); cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    expect_all("stop on tick", 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
    cyc();
    chk("stop on tick after", {3'b0, cnt_en}, 4'd0);
    clr = 1'b1; start = 1'b1; cyc(); clr = 1'b0; start = 1'b0;
    expect_all("clr+start", 1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
    cyc();
    expect_all("clr+start after", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    cyc();
    chk("clr+start idle", {2'b0, state}, 4'd0);
    $display("seq priority: stop/tick and clr/start checked");

    // Reset mid-run one cycle before the tick, then exactly on the tick.
    for (int v = 0; v < 2; v++) begin
      do_reset();
      start = 1'b1; cyc(); start = 1'b0;
      cyc(); cyc();
      if (v == 1) cyc();
      rst = 1'b0; cyc(); rst = 1'b1;
      expect_all($sformatf("midrst%0d during", v), 1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
      cyc();
      expect_all($sformatf("midrst%0d release", v), 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
      for (int k = 0; k < 5; k++) begin
        cyc();
        chk($sformatf("midrst%0d en %0d", v, k), {3'b0, cnt_en}, 4'd0);
      end
      $display("seq midrst%0d: no step after reset", v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
